// File: rtl/idp_pkg.sv
// Shared constants and types for the IDP link transmit scheduler.
// Word width follows `IBLEN11 when the encoder headers define it.
`ifndef IBLEN11
`define IBLEN11 14
`endif

package idp_pkg;

  localparam int unsigned IDP_DW       = `IBLEN11;
  localparam int unsigned IDP_CODE_MAX = 10000;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    SYNC = 1'b1
  } sched_state_t;

  typedef logic [IDP_DW-1:0] idp_word_t;

endpackage

// File: rtl/idp_link_tx_sched_if.sv
// Requester handshake and encoder-side bus of the IDP link transmit scheduler.
// slave = scheduler view, master = requester/encoder-side view.
interface idp_link_tx_sched_if import idp_pkg::*; #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = IDP_DW
) ();

  localparam int unsigned SW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               link_stall;
  logic [DW-1:0]      enc_data;
  logic               enc_load;
  logic [SW-1:0]      enc_src;
  logic               enc_sync;
  logic               err_range;
  logic [SW-1:0]      err_src;

  modport master (
    output req_valid, req_data, link_stall,
    input  req_ready, enc_data, enc_load, enc_src, enc_sync, err_range, err_src
  );

  modport slave (
    input  req_valid, req_data, link_stall,
    output req_ready, enc_data, enc_load, enc_src, enc_sync, err_range, err_src
  );

endinterface

// File: rtl/idp_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping
// from NREQ-1 to 0. Produces one-hot grant, its index and an any-request flag.
module idp_rr_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  int unsigned k;

  always_comb begin
    k   = 0;
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = (32'(ptr) + i) % NREQ;
      if (!any && req[k]) begin
        any = 1'b1;
        idx = PW'(k);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/idp_link_tx_sched.sv
// Round-robin scheduler feeding one IDP_encoder_11 from NREQ requesters, with range
// check and optional periodic sync word insertion (enabled by `IDP_SYNC_INSERT_EN).
module idp_link_tx_sched import idp_pkg::*; #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned DW          = IDP_DW,
  parameter int unsigned CODE_MAX    = IDP_CODE_MAX,
  parameter int unsigned SYNC_PERIOD = 64,
  parameter int unsigned SYNC_WORD   = 0
) (
  input  logic              clock,
  input  logic              rst_n,
  idp_link_tx_sched_if.slave bus
);

  localparam int unsigned SW = $clog2(NREQ);
  localparam logic [DW:0] CodeLimit = (DW+1)'(CODE_MAX);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("NREQ must be in 2..8");
  end
  if (SYNC_PERIOD == 0 || SYNC_WORD >= CODE_MAX) begin : g_bad_sync
    $error("SYNC_PERIOD must be nonzero and SYNC_WORD below CODE_MAX");
  end

  logic [SW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] arb_req, gnt;
  logic [SW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            run, can_grant, hs, word_ok, fwd, sync_emit;
  logic [DW-1:0]   word;

  logic [DW-1:0]   enc_data_q, enc_data_d;
  logic            enc_load_q, enc_load_d;
  logic [SW-1:0]   enc_src_q, enc_src_d;
  logic            err_range_q, err_range_d;
  logic [SW-1:0]   err_src_q, err_src_d;

  // Held in reset, nothing may be granted even though the pointer reads 0.
  assign can_grant = rst_n & ~bus.link_stall & run;
  assign arb_req   = can_grant ? bus.req_valid : '0;

  idp_rr_arb #(
    .NREQ(NREQ),
    .PW  (SW)
  ) u_arb (
    .req(arb_req),
    .ptr(ptr_q),
    .gnt(gnt),
    .idx(gnt_idx),
    .any(gnt_any)
  );

  assign bus.req_ready = gnt;
  assign hs            = gnt_any;
  assign word          = bus.req_data[gnt_idx*DW +: DW];
  assign word_ok       = {1'b0, word} < CodeLimit;
  assign fwd           = hs & word_ok;

  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = (gnt_idx == SW'(NREQ - 1)) ? '0 : gnt_idx + SW'(1);
  end

`ifdef IDP_SYNC_INSERT_EN
  localparam int unsigned CW = $clog2(SYNC_PERIOD + 1);
  localparam logic [0:0] StRun  = RUN;
  localparam logic [0:0] StSync = SYNC;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          enc_sync_q, enc_sync_d;

  // Only forwarded data beats advance the counter; dropped words do not.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sync_emit = 1'b0;
    case (state_q)
      StRun: begin
        if (fwd) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(SYNC_PERIOD)) state_d = StSync;
        end
      end
      StSync: begin
        if (!bus.link_stall) begin
          sync_emit = 1'b1;
          cnt_d     = '0;
          state_d   = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  assign run = (state_q == StRun);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      cnt_q      <= '0;
      enc_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      enc_sync_q <= enc_sync_d;
    end
  end

  always_comb begin
    enc_sync_d = enc_sync_q;
    if (fwd)       enc_sync_d = 1'b0;
    if (sync_emit) enc_sync_d = 1'b1;
  end

  assign bus.enc_sync = enc_sync_q;
`else
  assign run          = 1'b1;
  assign sync_emit    = 1'b0;
  assign bus.enc_sync = 1'b0;
`endif

  // Data and source hold when nothing is loaded so the TSVs do not toggle.
  always_comb begin
    enc_data_d  = enc_data_q;
    enc_load_d  = 1'b0;
    enc_src_d   = enc_src_q;
    err_range_d = 1'b0;
    err_src_d   = err_src_q;
    if (fwd) begin
      enc_data_d = word;
      enc_load_d = 1'b1;
      enc_src_d  = gnt_idx;
    end
    if (hs && !word_ok) begin
      err_range_d = 1'b1;
      err_src_d   = gnt_idx;
    end
    if (sync_emit) begin
      enc_data_d = DW'(SYNC_WORD);
      enc_load_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      enc_data_q  <= '0;
      enc_load_q  <= 1'b0;
      enc_src_q   <= '0;
      err_range_q <= 1'b0;
      err_src_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      enc_data_q  <= enc_data_d;
      enc_load_q  <= enc_load_d;
      enc_src_q   <= enc_src_d;
      err_range_q <= err_range_d;
      err_src_q   <= err_src_d;
    end
  end

  assign bus.enc_data  = enc_data_q;
  assign bus.enc_load  = enc_load_q;
  assign bus.enc_src   = enc_src_q;
  assign bus.err_range = err_range_q;
  assign bus.err_src   = err_src_q;

endmodule

// File: tb/tb_idp_link_tx_sched.sv
// Directed bench for idp_link_tx_sched: reset, fairness, range drop, stall and
// sync insertion (sync expectations follow `IDP_SYNC_INSERT_EN).
module tb_idp_link_tx_sched;
  import idp_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 14;
  localparam int unsigned SP   = 16;

  logic clock = 1'b0;
  logic rst_n;
  always #5 clock = ~clock;

  idp_link_tx_sched_if #(.NREQ(NREQ), .DW(DW)) bus ();

  idp_link_tx_sched #(
    .NREQ       (NREQ),
    .DW         (DW),
    .CODE_MAX   (10000),
    .SYNC_PERIOD(SP),
    .SYNC_WORD  (0)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int n[NREQ];
  int ptr;
  int beats;
  bit sync_due;
  bit sync_on;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_data();
    idp_word_t w;
    for (int k = 0; k < NREQ; k++) begin
      w = idp_word_t'(k * 100 + n[k]);
      bus.req_data[k*DW +: DW] = w;
    end
  endtask

  initial begin
`ifdef IDP_SYNC_INSERT_EN
    sync_on = 1'b1;
`else
    sync_on = 1'b0;
`endif
    for (int k = 0; k < NREQ; k++) n[k] = 0;
    bus.link_stall = 1'b0;
    bus.req_valid  = '1;
    set_data();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", bus.req_ready, 0);
    check("rst_data", bus.enc_data, 0);
    check("rst_load", bus.enc_load, 0);
    check("rst_src", bus.enc_src, 0);
    check("rst_sync", bus.enc_sync, 0);
    check("rst_err", bus.err_range, 0);
    check("rst_errsrc", bus.err_src, 0);
    step();
    check("rst_hold_load", bus.enc_load, 0);
    rst_n = 1'b1;

    // Fairness: all valid, two full rounds.
    ptr = 0;
    for (int i = 0; i < 8; i++) begin
      #1 check("rr_ready", bus.req_ready, 1 << ptr);
      step();
      check("rr_load", bus.enc_load, 1);
      check("rr_src", bus.enc_src, ptr);
      check("rr_data", bus.enc_data, ptr * 100 + n[ptr]);
      n[ptr]++;
      set_data();
      ptr = (ptr + 1) % NREQ;
    end

    // Idle: outputs hold last word (req 3, second round -> 301).
    bus.req_valid = '0;
    #1 check("idle_ready", bus.req_ready, 0);
    step();
    check("idle_load", bus.enc_load, 0);
    check("idle_data", bus.enc_data, 301);
    check("idle_src", bus.enc_src, 3);

    // Out-of-range word from req 2 is accepted and dropped.
    bus.req_valid = 4'b0100;
    bus.req_data[2*DW +: DW] = 14'd10000;
    #1 check("rng_ready", bus.req_ready, 4'b0100);
    step();
    check("rng_err", bus.err_range, 1);
    check("rng_errsrc", bus.err_src, 2);
    check("rng_load", bus.enc_load, 0);
    check("rng_data", bus.enc_data, 301);
    bus.req_valid = '0;
    step();
    check("rng_pulse", bus.err_range, 0);
    check("rng_errsrc_hold", bus.err_src, 2);

    // Largest legal word, granted after wrap from pointer 3.
    bus.req_valid = 4'b0100;
    bus.req_data[2*DW +: DW] = 14'd9999;
    #1 check("max_ready", bus.req_ready, 4'b0100);
    step();
    check("max_load", bus.enc_load, 1);
    check("max_data", bus.enc_data, 9999);
    check("max_src", bus.enc_src, 2);
    check("max_err", bus.err_range, 0);

    // Stall for 5 cycles with req 1 pending.
    bus.link_stall = 1'b1;
    bus.req_valid  = 4'b0010;
    bus.req_data[1*DW +: DW] = 14'd555;
    for (int i = 0; i < 5; i++) begin
      #1 check("stl_ready", bus.req_ready, 0);
      step();
      check("stl_load", bus.enc_load, 0);
      check("stl_data", bus.enc_data, 9999);
    end
    bus.link_stall = 1'b0;
    #1 check("stl_rel_ready", bus.req_ready, 4'b0010);
    step();
    check("stl_rel_load", bus.enc_load, 1);
    check("stl_rel_src", bus.enc_src, 1);
    check("stl_rel_data", bus.enc_data, 555);
    bus.req_valid = '0;

    // Fresh reset, then continuous traffic with a small model of sync insertion.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < NREQ; k++) n[k] = 0;
    set_data();
    bus.req_valid = '1;
    ptr      = 0;
    beats    = 0;
    sync_due = 1'b0;
    for (int i = 0; i < 36; i++) begin
      if (sync_due) begin
        #1 check("syn_ready", bus.req_ready, 0);
        step();
        check("syn_load", bus.enc_load, 1);
        check("syn_flag", bus.enc_sync, 1);
        check("syn_data", bus.enc_data, 0);
        sync_due = 1'b0;
      end else begin
        #1 check("dat_ready", bus.req_ready, 1 << ptr);
        step();
        check("dat_load", bus.enc_load, 1);
        check("dat_flag", bus.enc_sync, 0);
        check("dat_src", bus.enc_src, ptr);
        check("dat_data", bus.enc_data, ptr * 100 + n[ptr]);
        n[ptr]++;
        set_data();
        ptr = (ptr + 1) % NREQ;
        beats++;
        if (sync_on && beats == SP) begin
          sync_due = 1'b1;
          beats    = 0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
